// File: rtl/kernel_conv3x3.sv
// Programmable signed 3x3 convolution with round/shift/clamp; non-pixel words pass through in 3 cycles.
// Optional macro KERNEL_CONV_BYPASS_EN adds a frame-latched bypass that outputs the center element.
module kernel_conv3x3 #(
   parameter int PIXEL_WIDTH = 10,
   parameter int DATA_WIDTH  = 16,
   parameter int COEF_WIDTH  = 8,
   parameter int SHIFT_WIDTH = 4,
   parameter int DTYPE_WIDTH = 8,
   parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 8'h01,
   parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 8'hE0
) (
   input  logic                     clk,
   input  logic                     resetb,
   input  logic                     dvi,
   input  logic [DTYPE_WIDTH-1:0]   dtypei,
   input  logic [DATA_WIDTH-1:0]    meta_datai,
   input  logic [9*PIXEL_WIDTH-1:0] kernel_datai,
   input  logic                     coef_we,
   input  logic [3:0]               coef_addr,
   input  logic [COEF_WIDTH-1:0]    coef_wdata,
   output logic                     dvo,
   output logic [DTYPE_WIDTH-1:0]   dtypeo,
   output logic [DATA_WIDTH-1:0]    datao
);
   localparam int PROD_W = PIXEL_WIDTH + COEF_WIDTH + 1;
   localparam int SUM_W  = PIXEL_WIDTH + COEF_WIDTH + 5;
   localparam logic [COEF_WIDTH-1:0] COEF_ONE = {{(COEF_WIDTH-1){1'b0}}, 1'b1};

   logic signed [COEF_WIDTH-1:0]  stage_coef_r [9];
   logic signed [COEF_WIDTH-1:0]  stage_coef_s [9];
   logic signed [COEF_WIDTH-1:0]  act_coef_r   [9];
   logic [SHIFT_WIDTH-1:0]        stage_shift_r, stage_shift_s, act_shift_r;
   logic                          frame_start_s;
   logic [PIXEL_WIDTH-1:0]        pix_s [9];

   logic signed [PROD_W-1:0]      s1_prod_r [9];
   logic                          s1_dv_r, s2_dv_r;
   logic [DTYPE_WIDTH-1:0]        s1_dtype_r, s2_dtype_r;
   logic [DATA_WIDTH-1:0]         s1_meta_r, s2_meta_r;
   logic [SHIFT_WIDTH-1:0]        s1_shift_r, s2_shift_r;
   logic signed [SUM_W-1:0]       sum_s, s2_sum_r, round_s, shifted_s;
   logic [PIXEL_WIDTH-1:0]        clamp_s;
   logic [DATA_WIDTH-1:0]         datao_s;
`ifdef KERNEL_CONV_BYPASS_EN
   logic                          stage_bypass_r, stage_bypass_s, act_bypass_r;
   logic                          s1_bypass_r, s2_bypass_r;
   logic [PIXEL_WIDTH-1:0]        s1_center_r, s2_center_r;
`endif

   assign frame_start_s = dvi && (dtypei == DTYPE_FRAME_START);

   // Unpack the window and apply this cycle's write to the staging image.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         pix_s[i] = kernel_datai[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
      stage_coef_s  = stage_coef_r;
      stage_shift_s = stage_shift_r;
`ifdef KERNEL_CONV_BYPASS_EN
      stage_bypass_s = stage_bypass_r;
`endif
      if (coef_we) begin
         if (coef_addr < 4'd9) begin
            stage_coef_s[coef_addr] = coef_wdata;
         end else if (coef_addr == 4'd9) begin
            stage_shift_s = coef_wdata[SHIFT_WIDTH-1:0];
`ifdef KERNEL_CONV_BYPASS_EN
         end else if (coef_addr == 4'd10) begin
            stage_bypass_s = coef_wdata[0];
`endif
         end else begin
            stage_shift_s = stage_shift_r;
         end
      end else begin
         stage_shift_s = stage_shift_r;
      end
   end

   // Staging and active banks; active follows the written staging image at frame start.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < 9; i++) begin
            stage_coef_r[i] <= (i == 4) ? COEF_ONE : '0;
            act_coef_r[i]   <= (i == 4) ? COEF_ONE : '0;
         end
         stage_shift_r <= '0;
         act_shift_r   <= '0;
`ifdef KERNEL_CONV_BYPASS_EN
         stage_bypass_r <= 1'b0;
         act_bypass_r   <= 1'b0;
`endif
      end else begin
         stage_coef_r  <= stage_coef_s;
         stage_shift_r <= stage_shift_s;
`ifdef KERNEL_CONV_BYPASS_EN
         stage_bypass_r <= stage_bypass_s;
`endif
         if (frame_start_s) begin
            act_coef_r  <= stage_coef_s;
            act_shift_r <= stage_shift_s;
`ifdef KERNEL_CONV_BYPASS_EN
            act_bypass_r <= stage_bypass_s;
`endif
         end
      end
   end

   // Product sum, round, arithmetic shift and clamp.
   always_comb begin
      sum_s = '0;
      for (int i = 0; i < 9; i++) begin
         sum_s = sum_s + s1_prod_r[i];
      end
      round_s = '0;
      if (s2_shift_r != '0) begin
         round_s[s2_shift_r - 1'b1] = 1'b1;
      end else begin
         round_s = '0;
      end
      shifted_s = (s2_sum_r + round_s) >>> s2_shift_r;
      if (shifted_s[SUM_W-1]) begin
         clamp_s = '0;
      end else if (shifted_s[SUM_W-2:PIXEL_WIDTH] != '0) begin
         clamp_s = '1;
      end else begin
         clamp_s = shifted_s[PIXEL_WIDTH-1:0];
      end
`ifdef KERNEL_CONV_BYPASS_EN
      if (s2_bypass_r) begin
         clamp_s = s2_center_r;
      end else begin
         clamp_s = clamp_s;
      end
`endif
      if (s2_dv_r && ((s2_dtype_r & DTYPE_PIXEL_MASK) != '0)) begin
         datao_s = {{(DATA_WIDTH-PIXEL_WIDTH){1'b0}}, clamp_s};
      end else begin
         datao_s = s2_meta_r;
      end
   end

   // Three-stage datapath with sideband delay; outputs hold during bubbles.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < 9; i++) begin
            s1_prod_r[i] <= '0;
         end
         {s1_dv_r, s1_dtype_r, s1_meta_r, s1_shift_r} <= '0;
         {s2_dv_r, s2_dtype_r, s2_meta_r, s2_shift_r, s2_sum_r} <= '0;
         dvo    <= 1'b0;
         dtypeo <= '0;
         datao  <= '0;
`ifdef KERNEL_CONV_BYPASS_EN
         {s1_bypass_r, s1_center_r, s2_bypass_r, s2_center_r} <= '0;
`endif
      end else begin
         for (int i = 0; i < 9; i++) begin
            s1_prod_r[i] <= $signed({1'b0, pix_s[i]}) * act_coef_r[i];
         end
         s1_dv_r    <= dvi;
         s1_dtype_r <= dtypei;
         s1_meta_r  <= meta_datai;
         s1_shift_r <= act_shift_r;
         s2_dv_r    <= s1_dv_r;
         s2_dtype_r <= s1_dtype_r;
         s2_meta_r  <= s1_meta_r;
         s2_shift_r <= s1_shift_r;
         s2_sum_r   <= sum_s;
`ifdef KERNEL_CONV_BYPASS_EN
         s1_bypass_r <= act_bypass_r;
         s1_center_r <= pix_s[4];
         s2_bypass_r <= s1_bypass_r;
         s2_center_r <= s1_center_r;
`endif
         dvo <= s2_dv_r;
         if (s2_dv_r) begin
            dtypeo <= s2_dtype_r;
            datao  <= datao_s;
         end
      end
   end
endmodule

// File: tb/tb_kernel_conv3x3.sv
// Scoreboard bench for kernel_conv3x3: driver pushes expected words, a negedge monitor pops and compares.
module tb_kernel_conv3x3;
   localparam logic [7:0] T_FS = 8'h01, T_RS = 8'h04, T_RE = 8'h08, T_HDR = 8'h10, T_RAW = 8'h20;

   logic        clk = 1'b0;
   logic        resetb;
   logic        dvi;
   logic [7:0]  dtypei;
   logic [15:0] meta_datai;
   logic [89:0] kernel_datai;
   logic        coef_we;
   logic [3:0]  coef_addr;
   logic [7:0]  coef_wdata;
   logic        dvo;
   logic [7:0]  dtypeo;
   logic [15:0] datao;

   typedef struct {
      logic [7:0]  dt;
      logic [15:0] d;
      int          cyc;
   } exp_t;
   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   kernel_conv3x3 dut (
      .clk(clk), .resetb(resetb), .dvi(dvi), .dtypei(dtypei), .meta_datai(meta_datai),
      .kernel_datai(kernel_datai), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_wdata(coef_wdata), .dvo(dvo), .dtypeo(dtypeo), .datao(datao)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [89:0] win(input logic [9:0] ctr, input logic [9:0] oth);
      logic [89:0] w;
      for (int i = 0; i < 9; i++) w[i*10 +: 10] = (i == 4) ? ctr : oth;
      return w;
   endfunction

   task automatic drive(input logic dv, input logic [7:0] dt, input logic [15:0] meta,
                        input logic [89:0] k, input logic we, input logic [3:0] a,
                        input logic [7:0] wd, input logic [15:0] exp_d);
      exp_t e;
      @(negedge clk);
      dvi = dv; dtypei = dt; meta_datai = meta; kernel_datai = k;
      coef_we = we; coef_addr = a; coef_wdata = wd;
      if (dv) begin
         e.dt = dt; e.d = exp_d; e.cyc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic word(input logic [7:0] dt, input logic [15:0] meta, input logic [89:0] k,
                       input logic [15:0] exp_d);
      drive(1'b1, dt, meta, k, 1'b0, 4'd0, 8'd0, exp_d);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      drive(1'b0, 8'h00, 16'h0000, 90'd0, 1'b1, a, d, 16'h0000);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 16'h0000, 90'd0, 1'b0, 4'd0, 8'd0, 16'h0000);
   endtask

   task automatic set_all(input logic [7:0] oth, input logic [7:0] ctr, input logic [3:0] sh);
      for (int i = 0; i < 9; i++) wr(4'(i), (i == 4) ? ctr : oth);
      wr(4'd9, {4'd0, sh});
   endtask

   // Monitor: every valid output must match the oldest expectation with latency 3.
   always @(negedge clk) begin
      if (resetb === 1'b1 && dvo === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_dvo", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("dtypeo", int'(dtypeo), int'(e.dt));
            check("datao", int'(datao), int'(e.d));
            check("latency", cyc - e.cyc, 3);
         end
      end
   end

   initial begin
      resetb = 1'b0; dvi = 1'b0; dtypei = 8'h00; meta_datai = 16'h0000; kernel_datai = 90'd0;
      coef_we = 1'b0; coef_addr = 4'd0; coef_wdata = 8'd0;
      repeat (3) @(negedge clk);
      check("reset_dvo", int'(dvo), 0);
      check("reset_dtypeo", int'(dtypeo), 0);
      check("reset_datao", int'(datao), 0);
      resetb = 1'b1;

      // identity after reset
      word(T_FS, 16'h0000, 90'd0, 16'h0000);
      word(T_RAW, 16'h1111, win(10'h155, 10'h3FF), 16'h0155);
      // box blur: 900 + 4 >> 3
      set_all(8'd1, 8'd1, 4'd3);
      word(T_FS, 16'h0000, 90'd0, 16'h0000);
      word(T_RAW, 16'h0000, win(10'd100, 10'd100), 16'd113);
      // negative clamp
      set_all(8'd0, 8'hFF, 4'd0);
      word(T_FS, 16'h0000, 90'd0, 16'h0000);
      word(T_RAW, 16'h0000, win(10'd5, 10'd5), 16'd0);
      // overflow clamp
      set_all(8'd127, 8'd127, 4'd0);
      word(T_FS, 16'h0000, 90'd0, 16'h0000);
      word(T_RAW, 16'h0000, win(10'd1023, 10'd1023), 16'd1023);
      // mid-frame writes stay staged
      word(T_RAW, 16'h0000, win(10'd2, 10'd2), 16'd1023);
      set_all(8'd0, 8'd1, 4'd0);
      word(T_RAW, 16'h0000, win(10'd2, 10'd2), 16'd1023);
      // same-cycle write with frame start: center becomes 3
      drive(1'b1, T_FS, 16'h0000, 90'd0, 1'b1, 4'd4, 8'd3, 16'h0000);
      word(T_RAW, 16'h0000, win(10'd7, 10'd2), 16'd21);
      // pass-through and bubbles
      word(T_HDR, 16'h0506, win(10'd1, 10'd1), 16'h0506);
      word(T_RS, 16'h0001, win(10'd9, 10'd9), 16'h0001);
      idle(2);
      word(T_RAW, 16'hBEEF, win(10'd7, 10'd9), 16'd21);
      idle(1);
      word(T_RE, 16'h00AB, win(10'd3, 10'd3), 16'h00AB);
      // bypass bit at address 10
      set_all(8'd1, 8'd1, 4'd0);
      wr(4'd10, 8'd1);
      word(T_FS, 16'h0000, 90'd0, 16'h0000);
`ifdef KERNEL_CONV_BYPASS_EN
      word(T_RAW, 16'h0000, win(10'h2A, 10'd1), 16'h002A);
`else
      word(T_RAW, 16'h0000, win(10'h2A, 10'd1), 16'd50);
`endif
      idle(1);
      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      check("drain", q.size(), 0);
      idle(3);
      check("bubble_dvo", int'(dvo), 0);
`ifdef KERNEL_CONV_BYPASS_EN
      check("hold_datao", int'(datao), 16'h002A);
`else
      check("hold_datao", int'(datao), 50);
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
